// File: rtl/freq_shift_iq_mc_if.sv
// freq_shift_iq_mc_if: input stream, tuning port and output stream of the multi-channel shifter.
interface freq_shift_iq_mc_if #(
  parameter int DATA_WIDTH = 16,
  parameter int PHASE_WIDTH = 24,
  parameter int CH_W = 2
);
  logic [2*DATA_WIDTH-1:0] in_tdata;
  logic in_tvalid, in_tready, in_tlast;
  logic cfg_valid, cfg_clr;
  logic [CH_W-1:0] cfg_ch;
  logic [PHASE_WIDTH-1:0] cfg_inc;
  logic [2*DATA_WIDTH-1:0] out_tdata;
  logic [CH_W-1:0] out_tuser;
  logic out_tvalid, out_tready, out_tlast;
  modport master (
    output in_tdata, in_tvalid, in_tlast, cfg_valid, cfg_ch, cfg_inc, cfg_clr, out_tready,
    input in_tready, out_tdata, out_tuser, out_tvalid, out_tlast
  );
  modport slave (
    input in_tdata, in_tvalid, in_tlast, cfg_valid, cfg_ch, cfg_inc, cfg_clr, out_tready,
    output in_tready, out_tdata, out_tuser, out_tvalid, out_tlast
  );
endinterface

// File: rtl/freq_shift_iq_mc.sv
// freq_shift_iq_mc: time-interleaved multi-channel complex frequency shifter, one NCO per channel.
module freq_shift_iq_mc #(
  parameter int DATA_WIDTH = 16,
  parameter int SIN_COS_WIDTH = 16,
  parameter int PHASE_WIDTH = 24,
  parameter int LUT_WIDTH = 10,
  parameter int NUM_CH = 4,
  parameter int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input logic clk,
  input logic reset,
  freq_shift_iq_mc_if.slave bus
);
  localparam int DW = DATA_WIDTH;
  localparam int SW = SIN_COS_WIDTH;
  localparam int PW = DW + SW;
  localparam int QN = 2 ** (LUT_WIDTH - 2);
  localparam real AMP = 2.0 ** (SW - 1) - 1.0;
  localparam real PI = 3.14159265358979323846;
  localparam logic signed [PW:0] RND = (PW + 1)'(2 ** (SW - 2));
  localparam logic signed [PW:0] MAXV = (PW + 1)'(2 ** (DW - 1) - 1);
  localparam logic signed [PW:0] MINV = -MAXV - 1;

  logic w_en, w_acc;
  logic [CH_W-1:0] r_ch;
  logic [PHASE_WIDTH-1:0] r_acc [NUM_CH];
  logic [PHASE_WIDTH-1:0] r_inc [NUM_CH];
  logic r1_v, r1_last, r2_v, r2_last, r3_v, r3_last, r_ov, r_ol;
  logic [CH_W-1:0] r1_ch, r2_ch, r3_ch, r_ou;
  logic signed [DW-1:0] r1_i, r1_q, r2_i, r2_q;
  logic [LUT_WIDTH-1:0] r1_k;
  logic signed [SW-1:0] r2_cos, r2_sin;
  logic signed [PW-1:0] r3_ic, r3_qs, r3_is, r3_qc;
  logic [2*DW-1:0] r_od;
  logic signed [SW-1:0] w_qrom [0:QN];
  logic [LUT_WIDTH-1:0] w_k [2];
  logic signed [SW-1:0] w_rom [2];
  logic signed [PW:0] w_si, w_sq, w_ti, w_tq;

  assign w_en = bus.out_tready || !r_ov;
  assign w_acc = bus.in_tvalid && w_en && !reset;
  assign bus.in_tready = w_en && !reset;
  assign bus.out_tvalid = r_ov;
  assign bus.out_tdata = r_od;
  assign bus.out_tuser = r_ou;
  assign bus.out_tlast = r_ol;

  // Quarter-wave cosine table; the other three quadrants are folded from it.
  for (genvar j = 0; j <= QN; j++) begin : g_rom
    localparam real X = AMP * $cos(2.0 * PI * real'(j) / real'(4 * QN));
    assign w_qrom[j] = SW'($rtoi(X + 0.5));
  end

  assign w_k[0] = r1_k;
  assign w_k[1] = r1_k - LUT_WIDTH'(QN);
  for (genvar n = 0; n < 2; n++) begin : g_lut
    logic [LUT_WIDTH-2:0] w_fwd, w_rev;
    logic signed [SW-1:0] w_mag;
    assign w_fwd = {1'b0, w_k[n][LUT_WIDTH-3:0]};
    assign w_rev = (LUT_WIDTH - 1)'(QN) - w_fwd;
    assign w_mag = w_qrom[w_k[n][LUT_WIDTH-2] ? w_rev : w_fwd];
    assign w_rom[n] = (w_k[n][LUT_WIDTH-1] ^ w_k[n][LUT_WIDTH-2]) ? -w_mag : w_mag;
  end

  function automatic logic signed [DW-1:0] sat(input logic signed [PW:0] x);
    return (x > MAXV) ? MAXV[DW-1:0] : (x < MINV) ? MINV[DW-1:0] : x[DW-1:0];
  endfunction

  assign w_si = (PW + 1)'(r3_ic) - (PW + 1)'(r3_qs) + RND;
  assign w_sq = (PW + 1)'(r3_is) + (PW + 1)'(r3_qc) + RND;
  assign w_ti = w_si >>> (SW - 1);
  assign w_tq = w_sq >>> (SW - 1);

  // A clear on the tuning port wins over the increment of a same-cycle beat.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_ch <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_acc[c] <= '0;
        r_inc[c] <= '0;
      end
    end else begin
      if (w_acc) r_ch <= (bus.in_tlast || r_ch == CH_W'(NUM_CH - 1)) ? '0 : r_ch + 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_acc && r_ch == CH_W'(c)) r_acc[c] <= r_acc[c] + r_inc[c];
        if (bus.cfg_valid && bus.cfg_ch == CH_W'(c)) begin
          r_inc[c] <= bus.cfg_inc;
          if (bus.cfg_clr) r_acc[c] <= '0;
        end
      end
    end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      {r1_v, r1_last, r1_ch, r1_i, r1_q, r1_k} <= '0;
      {r2_v, r2_last, r2_ch, r2_i, r2_q, r2_cos, r2_sin} <= '0;
      {r3_v, r3_last, r3_ch, r3_ic, r3_qs, r3_is, r3_qc} <= '0;
      {r_ov, r_ol, r_ou, r_od} <= '0;
    end else if (w_en) begin
      r1_v <= w_acc;
      r1_last <= bus.in_tlast;
      r1_ch <= r_ch;
      r1_i <= bus.in_tdata[2*DW-1:DW];
      r1_q <= bus.in_tdata[DW-1:0];
      r1_k <= r_acc[r_ch][PHASE_WIDTH-1 -: LUT_WIDTH];
      r2_v <= r1_v;
      r2_last <= r1_last;
      r2_ch <= r1_ch;
      r2_i <= r1_i;
      r2_q <= r1_q;
      r2_cos <= w_rom[0];
      r2_sin <= w_rom[1];
      r3_v <= r2_v;
      r3_last <= r2_last;
      r3_ch <= r2_ch;
      r3_ic <= PW'(r2_i) * PW'(r2_cos);
      r3_qs <= PW'(r2_q) * PW'(r2_sin);
      r3_is <= PW'(r2_i) * PW'(r2_sin);
      r3_qc <= PW'(r2_q) * PW'(r2_cos);
      r_ov <= r3_v;
      r_ol <= r3_last;
      r_ou <= r3_ch;
      r_od <= {sat(w_ti), sat(w_tq)};
    end
endmodule

// File: doc/freq_shift_iq_mc.md
# freq_shift_iq_mc

Multi-channel, AXI-stream frequency shifter: a parametrised successor to the single-channel `freq_shift_iq`. It accepts time-interleaved complex samples for `NUM_CH` channels and keeps one phase accumulator per channel. Each sample is rotated by exp(+jθ), with θ taken from an internal quarter-symmetric sin/cos ROM. It supports full backpressure and runtime per-channel tuning. It sits between the DDC front end and the channeliser/packetiser.

## Interface
- `DATA_WIDTH`, 16, I and Q sample width (signed).
- `SIN_COS_WIDTH`, 16, ROM word width (signed).
- `PHASE_WIDTH`, 24, width of the phase accumulator and increment.
- `LUT_WIDTH`, 10, ROM address bits; full circle = 2^LUT_WIDTH entries.
- `NUM_CH`, 4, number of interleaved channels (≥1). `CH_W` = max(1, clog2(NUM_CH)).
- `clk` in 1: clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `in_tdata` in 2*DATA_WIDTH: {I, Q}, I in the upper half.
- `in_tvalid` in 1 / `in_tready` out 1 / `in_tlast` in 1: input stream.
- `cfg_valid` in 1: config strobe; single cycle, always accepted.
- `cfg_ch` in CH_W: target channel.
- `cfg_inc` in PHASE_WIDTH: new phase increment (two's complement; negative = down-shift).
- `cfg_clr` in 1: when `cfg_valid` is high, also clears the target accumulator to 0.
- `out_tdata` out 2*DATA_WIDTH: {I', Q'}.
- `out_tuser` out CH_W: channel index of the output sample.
- `out_tvalid` out 1 / `out_tready` in 1 / `out_tlast` out 1: output stream.

## Operation
- Channel counter `ch` selects the channel of each accepted beat (`in_tvalid && in_tready`). It increments per beat and wraps at NUM_CH-1→0. A beat with `in_tlast` forces `ch` to 0 for the next beat (frame realignment).
- Per-channel state: `acc[ch]` and `inc[ch]`. The sample is rotated by the **pre-increment** phase `acc[ch]`; then `acc[ch] <= acc[ch] + inc[ch]`, with modulo 2^PHASE_WIDTH wrap.
- Config write: `inc[cfg_ch] <= cfg_inc`.
  - The increment applied in the same cycle uses the old `inc`.
  - If `cfg_clr` is set, `acc[cfg_ch] <= 0`; clear wins over a same-cycle increment. A same-cycle accepted sample still uses the old phase.
- ROM address `k = acc[PHASE_WIDTH-1 -: LUT_WIDTH]` (truncation, no dither).
  - `T[k] = round(A·cos(2πk/2^LUT_WIDTH))`, with A = 2^(SIN_COS_WIDTH-1)-1, built at elaboration.
  - cos = T[k]; sin = T[(k - 2^(LUT_WIDTH-2)) mod 2^LUT_WIDTH].
- Arithmetic, with full-precision products:
  - I' = I·cos − Q·sin
  - Q' = I·sin + Q·cos
  - Each result adds 2^(SIN_COS_WIDTH-2), arithmetic-shifts right by SIN_COS_WIDTH-1, then saturates to [−2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)−1].
- `out_tlast` and `out_tuser` travel with their sample.
- Reset values: all accumulators, increments and `ch` are 0. `out_tvalid`, `out_tlast`, `out_tdata` and `out_tuser` are 0. `in_tready` is 0 while `reset` is high.

## Timing
- 4-stage pipeline:
  - S1: accept the beat, capture phase, update the accumulator.
  - S2: ROM read.
  - S3: multiplies.
  - S4: sum, round and saturate into the output register.
- Latency: 4 cycles from the accepting edge to `out_tvalid` when `out_tready` stays high. Throughput is 1 sample/clk.
- Global stall: `en = out_tready || !out_tvalid`, and `in_tready = en` (combinational). On a stall, all stages hold; no sample is dropped or duplicated. Accumulators advance only on accepted beats.
- Pipeline bubbles (gaps in `in_tvalid`) propagate as invalid stages. They do not block `en` except at the output register.
- `out_tdata` holds stable while `out_tvalid && !out_tready`.
- Reset asserted mid-stream flushes all in-flight samples. After deassertion, the first output appears 4 cycles after the first accepted beat, with channel 0 at phase 0.

## Test plan
- **Zero shift:** all `inc` = 0; input I=1000, Q=0 on every channel → each output is (1000, 0) after 4 cycles, with `out_tuser` cycling 0,1,2,3.
- **Quarter-turn:** default parameters, `inc[1]` = 2^22, input (1000, 0) continuous → channel 1 outputs cycle (1000,0), (0,1000), (−1000,0), (0,−1000). Other channels output (1000,0).
- **Saturation:** `inc[0]` = 2^21, input (−32768, −32768) → the second channel-0 output (π/4) is (0, −32768), saturated; the first is (−32767, −32767).
- **Backpressure:** random `out_tready` at 50% over 1000 beats → outputs match the reference model exactly, in order. `in_tready` falls in the same cycle as a stall at a full output.
- **Realign and config collision:**
  - `in_tlast` on the 2nd beat → the next beat is tagged `out_tuser` = 0.
  - `cfg_valid` + `cfg_clr` on ch 0 in the cycle a ch-0 beat is accepted → that sample uses the old phase, and the next ch-0 sample uses phase 0.
- **Reset mid-stream:** assert `reset` with 3 samples in flight → outputs go to 0 immediately. After release, there is no output until 4 cycles after a new beat, and the phase restarts at 0.
